dmem_responder: RTL and testbench

Memory-side responder for the data-cache miss/write-through interface: receives single-word writes and block-fill reads from the D-cache, applies a fixed access latency, and returns read data as a 4-word aligned burst. Sits between the D-cache memory port and the backing data storage; it is the target end of the readM2/writeM2/address2/data2 channel.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, block geometry and controller state encoding for
// the data-memory responder.
package dmem_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int BLOCK_WORDS = 4;
    localparam int BEAT_W      = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAT     = 3'd1,
        BURST   = 3'd2,
        WCOMMIT = 3'd3,
        DONE    = 3'd4
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage, synchronous write, registered read.
// Storage contents are never reset; only the read data register is.
// DEPTH is expected to be a power of two so the address wraps naturally.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem_r [0:DEPTH-1];

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

    // Registered read port; holds the last beat until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[addr];
        end else begin
            rd_data <= rd_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side target of the D-cache readM2/writeM2 channel.
// Accepts one request at a time, waits LATENCY cycles, then either commits a
// write or streams read data. Build option DMEM_BURST_EN: when defined, reads
// return the 4-word aligned block; when undefined, a single unaligned word.
// All outputs are registered; next-state logic computes the next output values.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readM2,
    input  logic                 writeM2,
    input  logic [WORD_SIZE-1:0] address2,
    input  logic [WORD_SIZE-1:0] data2_in,
    output logic [WORD_SIZE-1:0] data2_out,
    output logic                 data2_valid,
    output logic [1:0]           beat_index,
    output logic                 mem_busy,
    output logic                 mem_access_done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

`ifdef DMEM_BURST_EN
    localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;
`else
    localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd0;
`endif

    // Storage address of beat k; the block base is aligned only in burst
    // mode, and the sum wraps modulo DEPTH through the fixed address width.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] a,
        input logic [BEAT_W-1:0] k
    );
        logic [ADDR_W-1:0] base;
`ifdef DMEM_BURST_EN
        base = {a[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
`else
        base = a;
`endif
        return base + ADDR_W'(k);
    endfunction

    dmem_state_t          state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [ADDR_W-1:0]    addr_r, addr_s;
    logic [WORD_SIZE-1:0] data_r, data_s;
    logic                 is_write_r, is_write_s;
    logic [BEAT_W-1:0]    beat_r, beat_s;

    logic                 valid_r, valid_s;
    logic [BEAT_W-1:0]    beat_idx_r, beat_idx_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;

    logic [ADDR_W-1:0]    arr_addr_s;
    logic                 arr_we_s;
    logic                 arr_re_s;
    logic                 req_live_s;

    // Address bits above the storage range carry no meaning here.
    logic                 unused_addr_s;
    assign unused_addr_s = ^address2[WORD_SIZE-1:ADDR_W];

    // The request line that keeps the current transaction alive.
    assign req_live_s = is_write_r ? writeM2 : readM2;

    // Next-state, datapath latches, storage control and next output values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        addr_s     = addr_r;
        data_s     = data_r;
        is_write_s = is_write_r;
        beat_s     = beat_r;
        arr_addr_s = addr_r;
        arr_we_s   = 1'b0;
        arr_re_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (writeM2 || readM2) begin
                    state_s    = LAT;
                    cnt_s      = LAT_LOAD;
                    addr_s     = address2[ADDR_W-1:0];
                    data_s     = data2_in;
                    is_write_s = writeM2;   // write wins when both are high
                    beat_s     = 2'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LAT: begin
                if (!req_live_s) begin
                    state_s = IDLE;
                end else if (cnt_r == 4'd1) begin
                    if (is_write_r) begin
                        state_s = WCOMMIT;
                    end else begin
                        state_s    = BURST;
                        beat_s     = 2'd0;
                        arr_re_s   = 1'b1;
                        arr_addr_s = beat_addr(addr_r, 2'd0);
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            BURST: begin
                if (!req_live_s) begin
                    state_s = IDLE;
                end else if (beat_r == LAST_BEAT) begin
                    state_s = DONE;
                end else begin
                    beat_s     = beat_r + 2'd1;
                    arr_re_s   = 1'b1;
                    arr_addr_s = beat_addr(addr_r, beat_r + 2'd1);
                end
            end
            WCOMMIT: begin
                arr_we_s   = 1'b1;
                arr_addr_s = addr_r;
                state_s    = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        valid_s    = (state_s == BURST);
        beat_idx_s = (state_s == BURST) ? beat_s : 2'd0;
        busy_s     = (state_s == LAT) || (state_s == BURST) || (state_s == WCOMMIT);
        done_s     = (state_s == DONE);
    end

    // Controller state, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= '0;
            data_r     <= '0;
            is_write_r <= 1'b0;
            beat_r     <= 2'd0;
            valid_r    <= 1'b0;
            beat_idx_r <= 2'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            is_write_r <= is_write_s;
            beat_r     <= beat_s;
            valid_r    <= valid_s;
            beat_idx_r <= beat_idx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .addr    (arr_addr_s),
        .wr_en   (arr_we_s),
        .wr_data (data_r),
        .rd_en   (arr_re_s),
        .rd_data (data2_out)
    );

    assign data2_valid     = valid_r;
    assign beat_index      = beat_idx_r;
    assign mem_busy        = busy_r;
    assign mem_access_done = done_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. Expected read beats
// come from a bench-side memory model and are queued when a read is issued,
// then popped as the DUT presents beats. Follows DMEM_BURST_EN like the RTL.
module tb_dmem_responder;

    localparam int LAT = 4;
`ifdef DMEM_BURST_EN
    localparam int NB = 4;
`else
    localparam int NB = 1;
`endif

    logic        clk;
    logic        reset;
    logic        readM2;
    logic        writeM2;
    logic [15:0] address2;
    logic [15:0] data2_in;
    logic [15:0] data2_out;
    logic        data2_valid;
    logic [1:0]  beat_index;
    logic        mem_busy;
    logic        mem_access_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_mem [0:1023];

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  beat;
    } beat_t;

    beat_t exp_q[$];

    dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .readM2          (readM2),
        .writeM2         (writeM2),
        .address2        (address2),
        .data2_in        (data2_in),
        .data2_out       (data2_out),
        .data2_valid     (data2_valid),
        .beat_index      (beat_index),
        .mem_busy        (mem_busy),
        .mem_access_done (mem_access_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Queue the beats a read of addr should return according to the model.
    task automatic push_read_expect(input logic [15:0] addr);
        logic [9:0] a;
        logic [9:0] base;
        logic [9:0] ia;
        beat_t b;
        a = addr[9:0];
        base = (NB == 4) ? {a[9:2], 2'b00} : a;
        for (int k = 0; k < NB; k++) begin
            ia = base + 10'(k);
            b.data = model_mem[ia];
            b.beat = 2'(k);
            exp_q.push_back(b);
        end
    endtask

    // Issue one read and check every beat, its cycle, and the done pulse.
    task automatic run_read(input logic [15:0] addr, input string tag);
        int    done_cyc;
        int    nbeats;
        bit    busy_ok;
        bit    done_idle;
        beat_t e;
        push_read_expect(addr);
        @(negedge clk);
        readM2 = 1'b1;
        address2 = addr;
        @(posedge clk); #1;
        n_checks++;
        if (mem_busy !== 1'b1 || data2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept: busy=%b valid=%b, required busy=1 valid=0", tag, mem_busy, data2_valid);
        end
        done_cyc = -1; nbeats = 0; busy_ok = 1'b1; done_idle = 1'b0;
        for (int c = 1; c <= LAT + NB + 3 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (data2_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_beat: unexpected beat data=%h idx=%0d at cycle %0d, required none", tag, data2_out, beat_index, c);
                end else begin
                    e = exp_q.pop_front();
                    if (data2_out !== e.data || beat_index !== e.beat || c != LAT + nbeats) begin
                        n_fail++;
                        $display("FAIL %s_beat%0d: data=%h idx=%0d cycle=%0d, required data=%h idx=%0d cycle=%0d",
                                 tag, nbeats, data2_out, beat_index, c, e.data, e.beat, LAT + nbeats);
                    end
                end
                nbeats++;
            end
            if (mem_access_done === 1'b1) begin
                done_cyc = c;
                done_idle = (mem_busy === 1'b0) && (data2_valid === 1'b0);
                readM2 = 1'b0;
            end else if (mem_busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        readM2 = 1'b0;
        n_checks++;
        if (done_cyc != LAT + NB || nbeats != NB || !busy_ok || !done_idle || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_done: done_cycle=%0d beats=%0d busy_ok=%0b done_idle=%0b left=%0d, required done_cycle=%0d beats=%0d 1 1 0",
                     tag, done_cyc, nbeats, busy_ok, done_idle, exp_q.size(), LAT + NB, NB);
        end
        exp_q.delete();
        @(posedge clk); #1;
        n_checks++;
        if (mem_access_done !== 1'b0 || mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: done=%b busy=%b, required 0 0", tag, mem_access_done, mem_busy);
        end
    endtask

    // Issue one write (optionally with readM2 also high) and check its timing.
    task automatic run_write(input logic [15:0] addr, input logic [15:0] data, input bit both, input string tag);
        int done_cyc;
        bit busy_ok;
        bit saw_valid;
        @(negedge clk);
        writeM2 = 1'b1;
        readM2 = both;
        address2 = addr;
        data2_in = data;
        @(posedge clk); #1;
        n_checks++;
        if (mem_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: busy=%b, required 1", tag, mem_busy);
        end
        done_cyc = -1; busy_ok = 1'b1; saw_valid = 1'b0;
        for (int c = 1; c <= LAT + 4 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (data2_valid !== 1'b0) saw_valid = 1'b1;
            if (mem_access_done === 1'b1) begin
                done_cyc = c;
                if (mem_busy !== 1'b0) busy_ok = 1'b0;
                writeM2 = 1'b0;
                readM2 = 1'b0;
            end else if (mem_busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        writeM2 = 1'b0;
        readM2 = 1'b0;
        model_mem[addr[9:0]] = data;
        n_checks++;
        if (done_cyc != LAT + 1 || !busy_ok || saw_valid) begin
            n_fail++;
            $display("FAIL %s_done: done_cycle=%0d busy_ok=%0b saw_valid=%0b, required done_cycle=%0d 1 0",
                     tag, done_cyc, busy_ok, saw_valid, LAT + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; readM2 = 1'b0; writeM2 = 1'b0; address2 = 16'h0000; data2_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data2_out !== 16'h0000 || data2_valid !== 1'b0 || beat_index !== 2'd0 ||
            mem_busy !== 1'b0 || mem_access_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: out=%h valid=%b idx=%0d busy=%b done=%b, required all 0",
                     data2_out, data2_valid, beat_index, mem_busy, mem_access_done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mem_busy !== 1'b0 || data2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b valid=%b, required 0 0", mem_busy, data2_valid);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 4; i++) begin
            run_write(16'h0020 + 16'(i), 16'h00A0 + 16'(i), 1'b0, "pre20");
            run_write(16'h0014 + 16'(i), 16'h1400 + 16'(i), 1'b0, "pre14");
            run_write(16'h0030 + 16'(i), 16'h3000 + 16'(i), 1'b0, "pre30");
            run_write(16'h0040 + 16'(i), (i == 0) ? 16'h5555 : 16'h4000 + 16'(i), 1'b0, "pre40");
            run_write(16'h03FC + 16'(i), 16'hC3F0 + 16'(i), 1'b0, "pre3fc");
        end
    endtask

    task automatic test_read_block();
        run_read(16'h0022, "read22");
        run_read(16'h0020, "read20");
        run_read(16'hFC23, "read_upper_bits");
    endtask

    task automatic test_back_to_back();
        run_write(16'h0015, 16'hBEEF, 1'b0, "wr15");
        run_read(16'h0015, "raw15");
        run_read(16'h0014, "read14");
    endtask

    task automatic test_rw_both();
        run_write(16'h0030, 16'h1234, 1'b1, "both30");
        run_read(16'h0030, "read30");
    endtask

    task automatic test_abort();
        int drop_cyc;
        bit saw_done;
        drop_cyc = (NB == 4) ? LAT + 1 : 2;
        @(negedge clk);
        readM2 = 1'b1;
        address2 = 16'h0020;
        @(posedge clk);
        for (int c = 1; c <= drop_cyc; c++) @(posedge clk);
        #1;
        n_checks++;
        if (data2_valid !== (NB == 4) || mem_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_before: valid=%b busy=%b, required valid=%0d busy=1", data2_valid, mem_busy, (NB == 4));
        end
`ifdef DMEM_BURST_EN
        n_checks++;
        if (beat_index !== 2'd1 || data2_out !== model_mem[10'h021]) begin
            n_fail++;
            $display("FAIL abort_beat1: idx=%0d data=%h, required idx=1 data=%h", beat_index, data2_out, model_mem[10'h021]);
        end
`endif
        readM2 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (data2_valid !== 1'b0 || mem_busy !== 1'b0 || mem_access_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_read: valid=%b busy=%b done=%b, required 0 0 0", data2_valid, mem_busy, mem_access_done);
        end
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mem_access_done !== 1'b0 || data2_valid !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_quiet: activity after abort=1, required 0");
        end
        // Abort a write in its latency window: storage must keep the old word.
        @(negedge clk);
        writeM2 = 1'b1;
        address2 = 16'h0042;
        data2_in = 16'h7777;
        @(posedge clk);
        @(posedge clk); #1;
        writeM2 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mem_busy !== 1'b0 || mem_access_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write: busy=%b done=%b, required 0 0", mem_busy, mem_access_done);
        end
        repeat (LAT + 2) @(posedge clk);
        run_read(16'h0042, "read42_after_abort");
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        writeM2 = 1'b1;
        address2 = 16'h0040;
        data2_in = 16'h1111;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (data2_out !== 16'h0000 || data2_valid !== 1'b0 || beat_index !== 2'd0 ||
            mem_busy !== 1'b0 || mem_access_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_write: out=%h valid=%b idx=%0d busy=%b done=%b, required all 0",
                     data2_out, data2_valid, beat_index, mem_busy, mem_access_done);
        end
        @(negedge clk);
        writeM2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        n_checks++;
        if (mem_busy !== 1'b0 || mem_access_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume: busy=%b done=%b, required 0 0", mem_busy, mem_access_done);
        end
        run_read(16'h0040, "read40_after_reset");
    endtask

    task automatic test_wrap();
        run_read(16'h03FE, "read3fe");
        run_read(16'h03FF, "read3ff");
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_block();
        test_back_to_back();
        test_rw_both();
        test_abort();
        test_reset_mid_write();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
